// File: rtl/multiplexed_segment_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: mode codes, segment
// bit positions, the hex glyph table and the commit state encoding.
package seg_scan_pkg;

  localparam logic [1:0] MODE_HEX   = 2'b00;
  localparam logic [1:0] MODE_RAW   = 2'b01;
  localparam logic [1:0] MODE_LZS   = 2'b10;
  localparam logic [1:0] MODE_BLANK = 2'b11;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // {g,f,e,d,c,b,a} per nibble, entry 15 first; 6 and 9 carry tails, 7 does not.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/multiplexed_segment_scanner_if.sv
// Host write/commit bus of the segment scanner: the host fills the shadow
// buffer and requests a commit; the scanner reports whether one is pending.
interface multiplexed_segment_scanner_if #(
  parameter int DIGITS = 4
);
  localparam int WA = $clog2(DIGITS);

  logic          wr_en;
  logic [WA-1:0] wr_digit;
  logic [7:0]    wr_data;
  logic          commit;
  logic          pending;

  modport master (output wr_en, wr_digit, wr_data, commit, input pending);
  modport slave  (input wr_en, wr_digit, wr_data, commit, output pending);
endinterface

// File: rtl/multiplexed_segment_scanner_hex_seg_lut.sv
// Combinational hex nibble to 7-segment {g..a} lookup.
module hex_seg_lut
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);
  always_comb segs = HEX_GLYPH[nibble];
endmodule

// File: rtl/multiplexed_segment_scanner.sv
// Time-multiplexed 7-segment driver: shadow/active buffers with frame-aligned
// commit, hex/raw decode, leading-zero suppression and PWM dimming.
module multiplexed_segment_scanner
  import seg_scan_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int PRESCALE_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [1:0]                mode,
  input  logic                      lamp_test,
  input  logic                      active_low,
  input  logic [3:0]                brightness,
  multiplexed_segment_scanner_if.slave host,
  output logic                      frame_start,
  output logic [7:0]                seg_out,
  output logic [DIGITS-1:0]         dig_out
);
  localparam int WA = $clog2(DIGITS);
  localparam int P  = PRESCALE_LOG2;
  localparam logic [DIGITS-1:0] ALL_ONES = '1;

  logic [P-1:0]      presc_q, presc_d;
  logic [WA-1:0]     digit_q, digit_d;
  logic [7:0]        shadow_q [DIGITS];
  logic [7:0]        shadow_d [DIGITS];
  logic [7:0]        active_q [DIGITS];
  logic [7:0]        active_d [DIGITS];
  commit_state_e     state_q, state_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;

  logic              tc, wrap;
  logic [7:0]        cur;
  logic [6:0]        hex_segs;
  logic [DIGITS-1:0] nib_zero;
  logic              lzs_blank;
  logic [7:0]        glyph;
  logic              slot_lit;

  assign tc   = ena && (presc_q == '1);
  assign wrap = tc && (digit_q == WA'(DIGITS - 1));
  assign cur  = active_q[digit_q];

  hex_seg_lut u_lut (
    .nibble (cur[3:0]),
    .segs   (hex_segs)
  );

  // A digit above 0 goes dark when it and every more significant digit hold nibble 0.
  always_comb begin
    nib_zero = '0;
    for (int j = 0; j < DIGITS; j++) nib_zero[j] = (active_q[j][3:0] == 4'h0);
    lzs_blank = (digit_q != '0) && (&(nib_zero | ~(ALL_ONES << digit_q)));
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    glyph = 8'h00;
    case (mode)
      MODE_HEX: glyph = {cur[SEG_DP], hex_segs};
      MODE_RAW: glyph = cur;
      MODE_LZS: glyph = lzs_blank ? 8'h00 : {cur[SEG_DP], hex_segs};
      default:  glyph = 8'h00;
    endcase
    if (lamp_test) glyph = 8'hFF;
  end

  // Slot count 0 is a dark gap so the previous digit's segments never ghost.
  assign slot_lit = (presc_q != '0) && (presc_q[P-1 -: 4] <= brightness);

  always_comb begin
    presc_d  = presc_q;
    digit_d  = digit_q;
    shadow_d = shadow_q;
    active_d = active_q;
    state_d  = state_q;

    if (ena) presc_d = presc_q + 1'b1;
    if (tc)  digit_d = wrap ? '0 : digit_q + 1'b1;

    case (state_q)
      ST_IDLE:    if (host.commit) state_d = ST_PENDING;
      ST_PENDING: if (wrap) begin
        active_d = shadow_q;
        state_d  = host.commit ? ST_PENDING : ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase

    // Applied after the copy so a same-cycle write only reaches the shadow.
    if (host.wr_en && (32'(host.wr_digit) < DIGITS)) shadow_d[host.wr_digit] = host.wr_data;

    frame_start_d = wrap;
    seg_d         = ena ? glyph : 8'h00;
    dig_d         = (ena && slot_lit) ? (DIGITS'(1) << digit_q) : '0;
  end

  // NOTE: the display buffers are tiny register arrays, so they are reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      digit_q       <= '0;
      state_q       <= ST_IDLE;
      frame_start_q <= 1'b0;
      seg_q         <= 8'h00;
      dig_q         <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= 8'h00;
        active_q[i] <= 8'h00;
      end
    end else begin
      presc_q       <= presc_d;
      digit_q       <= digit_d;
      state_q       <= state_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign host.pending = (state_q == ST_PENDING);
  assign frame_start  = frame_start_q;
  assign seg_out      = seg_q ^ {8{active_low}};
  assign dig_out      = dig_q ^ {DIGITS{active_low}};
endmodule

// File: tb/tb_multiplexed_segment_scanner.sv
// Self-checking bench for multiplexed_segment_scanner: a count-based display
// model predicts every output cycle; directed scenarios plus random traffic.
module tb_multiplexed_segment_scanner;
  import seg_scan_pkg::*;

  localparam int D = 4;
  localparam int P = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, ena, lamp_test, active_low;
  logic [1:0]   mode;
  logic [3:0]   brightness;
  logic         frame_start;
  logic [7:0]   seg_out;
  logic [D-1:0] dig_out;

  multiplexed_segment_scanner_if #(.DIGITS(D)) hif ();

  multiplexed_segment_scanner #(.DIGITS(D), .PRESCALE_LOG2(P)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .lamp_test(lamp_test),
    .active_low(active_low), .brightness(brightness), .host(hif),
    .frame_start(frame_start), .seg_out(seg_out), .dig_out(dig_out)
  );

  // Six-digit instance for the wider digit-index checks.
  logic       ena6, lamp6, active_low6, fs6;
  logic [1:0] mode6;
  logic [3:0] bright6;
  logic [7:0] seg6;
  logic [5:0] dig6;

  multiplexed_segment_scanner_if #(.DIGITS(6)) hif6 ();

  multiplexed_segment_scanner #(.DIGITS(6), .PRESCALE_LOG2(P)) dut6 (
    .clk(clk), .rst_n(rst_n), .ena(ena6), .mode(mode6), .lamp_test(lamp6),
    .active_low(active_low6), .brightness(bright6), .host(hif6),
    .frame_start(fs6), .seg_out(seg6), .dig_out(dig6)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_t counts enabled cycles within a 64-cycle frame.
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int           m_t;
  logic [7:0]   m_shadow [D];
  logic [7:0]   m_active [D];
  bit           m_pend;
  logic [7:0]   e_seg;
  logic [D-1:0] e_dig;
  bit           e_fs;

  task automatic model_reset();
    m_t = 0; m_pend = 0; e_seg = '0; e_dig = '0; e_fs = 0;
    for (int i = 0; i < D; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
  endtask

  function automatic logic [7:0] ref_glyph(input int dg);
    logic [7:0] v;
    bit upper_zero;
    v = m_active[dg];
    upper_zero = 1;
    for (int j = dg; j < D; j++) if (m_active[j][3:0] != 4'h0) upper_zero = 0;
    if (lamp_test)         return 8'hFF;
    if (mode == MODE_RAW)  return v;
    if (mode == MODE_BLANK) return 8'h00;
    if (mode == MODE_LZS && dg > 0 && upper_zero) return 8'h00;
    return {v[7], hex_tbl[v[3:0]]};
  endfunction

  task automatic model_edge();
    int pr, dg;
    bit wrap;
    pr   = m_t % 16;
    dg   = m_t / 16;
    wrap = ena && (m_t == 63);
    e_seg = ena ? ref_glyph(dg) : 8'h00;
    // With a 16-cycle slot the top four prescaler bits are the whole slot count.
    e_dig = (ena && pr != 0 && pr <= int'(brightness)) ? D'(1 << dg) : '0;
    e_fs  = wrap;
    if (m_pend && wrap) begin
      for (int i = 0; i < D; i++) m_active[i] = m_shadow[i];
      m_pend = hif.commit;
    end else if (hif.commit) m_pend = 1;
    if (hif.wr_en && int'(hif.wr_digit) < D) m_shadow[hif.wr_digit] = hif.wr_data;
    if (ena) m_t = (m_t + 1) % 64;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("seg_out", 32'(seg_out), 32'(e_seg ^ {8{active_low}}));
    check("dig_out", 32'(dig_out), 32'(e_dig ^ {D{active_low}}));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("pending", 32'(hif.pending), 32'(m_pend));
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (frame_start !== 1'b1 && n < 300);
    check(tag, 32'(frame_start), 32'd1);
  endtask

  task automatic write_digit(input int d, input logic [7:0] v);
    hif.wr_en = 1'b1; hif.wr_digit = 2'(d); hif.wr_data = v;
    tick();
    hif.wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    hif.commit = 1'b1;
    tick();
    hif.commit = 1'b0;
  endtask

  task automatic frame_expect(input string tag, input logic [7:0] exp [D]);
    for (int i = 0; i < 64; i++) begin
      tick();
      for (int k = 0; k < D; k++) if (dig_out == D'(1 << k)) check(tag, 32'(seg_out), 32'(exp[k]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] scan_exp [D];
    logic [7:0] lzs_a [D];
    logic [7:0] lzs_b [D];
    logic [D-1:0] saved;
    int lit, lit5;
    bit seen6;

    scan_exp = '{8'h06, 8'h5B, 8'h4F, 8'h66};
    lzs_a    = '{8'h3F, 8'h00, 8'h00, 8'h00};
    lzs_b    = '{8'h07, 8'h3F, 8'h6D, 8'h00};

    ena = 1'b1; mode = MODE_HEX; lamp_test = 1'b0; active_low = 1'b1; brightness = 4'hF;
    hif.wr_en = 1'b0; hif.wr_digit = '0; hif.wr_data = '0; hif.commit = 1'b0;
    ena6 = 1'b0; mode6 = MODE_RAW; lamp6 = 1'b0; active_low6 = 1'b0; bright6 = 4'hF;
    hif6.wr_en = 1'b0; hif6.wr_digit = '0; hif6.wr_data = '0; hif6.commit = 1'b0;

    // Reset with inverted polarity: pins sit at all-off, i.e. all ones.
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_seg_pins", 32'(seg_out), 32'h0FF);
    check("rst_dig_pins", 32'(dig_out), 32'h00F);
    check("rst_pending", 32'(hif.pending), 32'd0);
    active_low = 1'b0;
    rst_n = 1'b1;
    tick();
    check("release_cycle1_dig", 32'(dig_out), 32'd0);
    tick();
    check("release_cycle2_dig", 32'(dig_out), 32'b0001);

    // Six-digit instance: digit 5 accepted, index 7 ignored.
    hif6.wr_en = 1'b1; hif6.wr_digit = 3'd5; hif6.wr_data = 8'h55; tick();
    hif6.wr_digit = 3'd7; hif6.wr_data = 8'hAA; tick();
    hif6.wr_en = 1'b0; hif6.commit = 1'b1; tick();
    hif6.commit = 1'b0;
    check("d6_pending_set", 32'(hif6.pending), 32'd1);
    ena6 = 1'b1;
    lit5 = 0; seen6 = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (seen6 && dig6 != '0) begin
        if (dig6 == 6'b100000) begin
          lit5++;
          check("d6_seg_digit5", 32'(seg6), 32'h55);
        end else check("d6_seg_other", 32'(seg6), 32'h00);
      end
      if (fs6) seen6 = 1;
    end
    check("d6_digit5_lit_cycles", 32'(lit5), 32'd15);
    check("d6_pending_clear", 32'(hif6.pending), 32'd0);

    // Basic scan: 1,2,3,4 in hex at full brightness.
    for (int d = 0; d < D; d++) write_digit(d, 8'(d + 1));
    pulse_commit();
    wait_fs("scan_wait_fs");
    for (int s = 0; s < D; s++) begin
      tick();
      check("scan_gap_dig", 32'(dig_out), 32'd0);
      lit = 0;
      for (int c = 0; c < 15; c++) begin
        tick();
        if (dig_out == D'(1 << s)) lit++;
        check("scan_seg", 32'(seg_out), 32'(scan_exp[s]));
      end
      check("scan_lit_cycles", 32'(lit), 32'd15);
    end
    check("scan_fs_period", 32'(frame_start), 32'd1);

    // Commit atomicity: a write in the apply cycle stays in the shadow.
    repeat (20) tick();
    write_digit(0, 8'h05);
    pulse_commit();
    check("atom_pending_set", 32'(hif.pending), 32'd1);
    for (int n = 0; n < 100 && m_t != 63; n++) tick();
    hif.wr_en = 1'b1; hif.wr_digit = 2'd0; hif.wr_data = 8'h08;
    tick();
    hif.wr_en = 1'b0;
    check("atom_pending_clear", 32'(hif.pending), 32'd0);
    tick();
    check("atom_digit0_prior", 32'(seg_out), 32'h6D);
    pulse_commit();
    wait_fs("atom_wait_fs");
    tick();
    check("atom_digit0_new", 32'(seg_out), 32'h7F);

    // Leading-zero suppression.
    mode = MODE_LZS;
    for (int d = 0; d < D; d++) write_digit(d, 8'h00);
    pulse_commit();
    wait_fs("lzs_a_wait_fs");
    frame_expect("lzs_all_zero", lzs_a);
    write_digit(0, 8'h07); write_digit(1, 8'h00); write_digit(2, 8'h05); write_digit(3, 8'h00);
    pulse_commit();
    wait_fs("lzs_b_wait_fs");
    frame_expect("lzs_0507", lzs_b);

    // PWM duty and lamp test.
    mode = MODE_HEX; brightness = 4'd3;
    wait_fs("pwm_wait_fs");
    lit = 0;
    for (int i = 0; i < 64; i++) begin tick(); if (dig_out != '0) lit++; end
    check("pwm_lit_per_frame", 32'(lit), 32'd12);
    mode = MODE_BLANK; lamp_test = 1'b1;
    tick(); tick();
    check("lamp_over_blank", 32'(seg_out), 32'hFF);
    lamp_test = 1'b0;
    tick(); tick();
    check("blank_seg", 32'(seg_out), 32'h00);

    // Scan enable low freezes the digit and darkens the outputs.
    mode = MODE_HEX; brightness = 4'hF;
    for (int n = 0; n < 100 && (m_t % 16) != 8; n++) tick();
    saved = dig_out;
    check("freeze_pre_lit", 32'(saved != '0), 32'd1);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("freeze_dig_off", 32'(dig_out), 32'd0);
      check("freeze_seg_off", 32'(seg_out), 32'd0);
    end
    ena = 1'b1;
    tick();
    check("freeze_resume_digit", 32'(dig_out), 32'(saved));

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (i % 97 == 0) begin
        mode       = 2'($urandom_range(0, 3));
        brightness = 4'($urandom_range(0, 15));
        active_low = 1'($urandom_range(0, 1));
      end
      lamp_test    = ($urandom_range(0, 15) == 0);
      hif.wr_en    = ($urandom_range(0, 3) == 0);
      hif.wr_digit = 2'($urandom_range(0, 3));
      hif.wr_data  = 8'($urandom);
      hif.commit   = ($urandom_range(0, 19) == 0);
      if (ena) ena = ($urandom_range(0, 49) != 0);
      else     ena = ($urandom_range(0, 7) == 0);
      tick();
    end
    ena = 1'b1; lamp_test = 1'b0; active_low = 1'b0; mode = MODE_HEX; brightness = 4'hF;
    hif.wr_en = 1'b0; hif.commit = 1'b0;
    repeat (4) tick();

    // Asynchronous reset mid-slot drops an in-flight commit at once.
    for (int n = 0; n < 100 && (m_t % 16) != 6; n++) tick();
    pulse_commit();
    check("async_pending_before", 32'(hif.pending), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_pending_cleared", 32'(hif.pending), 32'd0);
    check("async_dig_off", 32'(dig_out), 32'd0);
    check("async_seg_off", 32'(seg_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
